// File: rtl/ex_stage.sv
// Execute stage: ALU, sequential shift-add multiplier, branch/jump resolution
// and the registered EX/MEM pipeline register.
module ex_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [8:0]        ctrl_in,
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] rs_in,
  input  logic [DATA_W-1:0] rt_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic [DATA_W-1:0] offset_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              flush_in,
  output logic              stall_out,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              out_valid,
  output logic [5:0]        ctrl_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] store_data_out,
  output logic [RD_W-1:0]   rd_out,
  output logic [DATA_W-1:0] pc_out
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_ADDI = 4'b1000;
  localparam logic [3:0] OP_PASS = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_next;
  logic [DATA_W-1:0]  multiplicand, multiplier, acc;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  alu_result;
  logic               live, is_mul, mul_start, load, taken;

  // A wrong-path instruction sitting behind a redirect is squashed here.
  assign live   = in_valid & ~flush_in & ~redirect_valid;
  assign is_mul = (alu_op == OP_MUL);

  // ALU result; MUL reads the accumulated product, valid only in DONE.
  always_comb begin
    // NOTE: default first so no path through the case leaves the result unassigned (no latch).
    alu_result = '0;
    case (alu_op)
      OP_ADD:  alu_result = rs_in + rt_in;
      OP_SUB:  alu_result = rs_in - rt_in;
      OP_AND:  alu_result = rs_in & rt_in;
      OP_OR:   alu_result = rs_in | rt_in;
      OP_XOR:  alu_result = rs_in ^ rt_in;
      OP_SLL:  alu_result = rs_in << rt_in[SH_W-1:0];
      OP_SRL:  alu_result = rs_in >> rt_in[SH_W-1:0];
      OP_SRA:  alu_result = $signed(rs_in) >>> rt_in[SH_W-1:0];
      OP_ADDI: alu_result = rs_in + offset_in;
      OP_PASS: alu_result = rt_in;
      OP_MUL:  alu_result = acc;
      OP_SLT:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(rs_in) < $signed(rt_in))};
      default: alu_result = '0;
    endcase
  end

  // Branch/jump resolution on the result being loaded into EX/MEM.
  assign taken = load & (ctrl_in[7]
                       | (ctrl_in[6] & (alu_result == '0))
                       | (ctrl_in[5] & alu_result[DATA_W-1]));

  // Multiplier FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state, stall and load decode; flush aborts any multiply in flight.
  always_comb begin
    state_next = state;
    stall_out  = 1'b0;
    mul_start  = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (live && is_mul) begin
          stall_out  = 1'b1;
          mul_start  = 1'b1;
          state_next = BUSY;
        end else if (live) begin
          load = 1'b1;
        end
      end
      BUSY: begin
        if (flush_in) begin
          state_next = IDLE;
        end else begin
          stall_out = 1'b1;
          if (cnt == CNT_LAST) state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        load       = ~flush_in;
      end
      default: state_next = IDLE;
    endcase
    if (rst) stall_out = 1'b0;
  end

  // Shift-add multiplier datapath: one multiplier bit per BUSY cycle.
  always_ff @(posedge clk) begin
    // NOTE: these are working registers, not a memory array, so they take the synchronous reset too.
    if (rst) begin
      multiplicand <= '0;
      multiplier   <= '0;
      acc          <= '0;
      cnt          <= '0;
    end else if (mul_start) begin
      multiplicand <= rs_in;
      multiplier   <= rt_in;
      acc          <= '0;
      cnt          <= '0;
    end else if (state == BUSY && !flush_in) begin
      if (multiplier[0]) acc <= acc + multiplicand;
      multiplicand <= multiplicand << 1;
      multiplier   <= multiplier >> 1;
      cnt          <= cnt + CNT_W'(1);
    end
  end

  // EX/MEM pipeline register and the one-cycle redirect pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      out_valid      <= 1'b0;
      ctrl_out       <= '0;
      alu_result_out <= '0;
      store_data_out <= '0;
      rd_out         <= '0;
      pc_out         <= '0;
    end else begin
      redirect_valid <= taken;
      if (taken) redirect_pc <= rs_in;
      out_valid <= load;
      ctrl_out  <= load ? {ctrl_in[8], ctrl_in[4:0]} : 6'b0;
      if (load) begin
        alu_result_out <= alu_result;
        store_data_out <= rt_in;
        rd_out         <= rd_in;
        pc_out         <= pc_in;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases with literal expectations
// followed by randomized traffic compared against a behavioural model.
module tb_ex_stage;

  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [8:0]  ctrl_in;
  logic [3:0]  alu_op;
  logic [31:0] rs_in, rt_in, offset_in, pc_in;
  logic [5:0]  rd_in;
  logic        flush_in;
  logic        stall_out, redirect_valid, out_valid;
  logic [31:0] redirect_pc, alu_result_out, store_data_out, pc_out;
  logic [5:0]  ctrl_out, rd_out;

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  logic        m_ov, m_rv;
  logic [5:0]  m_ctrl, m_rd;
  logic [31:0] m_res, m_sd, m_pc, m_rpc, m_prod;
  int          m_age;        // -1 idle, 1..DW multiplying, DW+1 result ready
  logic        m_stall_last;
  logic        s_stall;      // DUT stall_out as last sampled

  ex_stage #(.DATA_W(32), .RD_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ctrl_in(ctrl_in), .alu_op(alu_op),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .offset_in(offset_in), .pc_in(pc_in),
    .flush_in(flush_in), .stall_out(stall_out), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .ctrl_out(ctrl_out),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out),
    .rd_out(rd_out), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return $signed(a) >>> b[4:0];
      4'd8:  return a + imm;
      4'd9:  return b;
      4'd10: return a * b;
      4'd11: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_ov = 0; m_rv = 0; m_ctrl = 0; m_rd = 0; m_res = 0; m_sd = 0; m_pc = 0;
    m_rpc = 0; m_prod = 0; m_age = -1; m_stall_last = 0;
  endtask

  // One clock: compare DUT against the model at the falling edge, then
  // advance the model across the rising edge.
  task automatic cycle();
    logic live, exp_stall, ld, tk;
    logic [31:0] res, n_prod;
    int n_age;
    @(negedge clk);
    live      = in_valid && !flush_in && !m_rv;
    exp_stall = 0;
    ld        = 0;
    res       = alu_ref(alu_op, rs_in, rt_in, offset_in);
    n_age     = m_age;
    n_prod    = m_prod;
    if (rst) begin
      n_age = -1;
    end else if (m_age < 0) begin
      if (live && alu_op == 4'b1010) begin
        exp_stall = 1; n_age = 1; n_prod = rs_in * rt_in;
      end else if (live) begin
        ld = 1;
      end
    end else if (m_age <= DW) begin
      if (flush_in) n_age = -1;
      else begin exp_stall = 1; n_age = m_age + 1; end
    end else begin
      n_age = -1;
      if (!flush_in) begin ld = 1; res = m_prod; end
    end
    tk = ld && (ctrl_in[7] || (ctrl_in[6] && res == 0) || (ctrl_in[5] && res[31]));

    s_stall = stall_out;
    check("stall_out", stall_out, exp_stall);
    check("out_valid", out_valid, m_ov);
    check("ctrl_out", ctrl_out, m_ctrl);
    check("alu_result_out", alu_result_out, m_res);
    check("store_data_out", store_data_out, m_sd);
    check("rd_out", rd_out, m_rd);
    check("pc_out", pc_out, m_pc);
    check("redirect_valid", redirect_valid, m_rv);
    check("redirect_pc", redirect_pc, m_rpc);

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_age = n_age; m_prod = n_prod; m_stall_last = exp_stall;
      m_rv = tk;
      if (tk) m_rpc = rs_in;
      m_ov = ld;
      m_ctrl = ld ? {ctrl_in[8], ctrl_in[4:0]} : 6'd0;
      if (ld) begin m_res = res; m_sd = rt_in; m_rd = rd_in; m_pc = pc_in; end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [8:0] c, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [5:0] rd);
    in_valid = v; ctrl_in = c; alu_op = op; rs_in = a; rt_in = b; rd_in = rd;
    offset_in = 32'h10; pc_in = pc_in + 1; flush_in = 0;
  endtask

  function automatic logic [31:0] rval();
    case ($urandom % 4)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000 | ($urandom % 64);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    rst = 1; pc_in = 0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("reset out_valid", out_valid, 0);
    check("reset ctrl_out", ctrl_out, 0);
    check("reset alu_result_out", alu_result_out, 0);
    check("reset stall_out", stall_out, 0);
    check("reset redirect_valid", redirect_valid, 0);
    rst = 0;

    // ADD wrap-around with RegWrt.
    drive(1, 9'h001, 4'd0, 32'hFFFF_FFFF, 32'd1, 6'd3);
    cycle();
    check("add wrap result", alu_result_out, 32'h0);
    check("add wrap ctrl", ctrl_out, 6'b000001);
    check("add wrap rd", rd_out, 6'd3);
    check("add wrap valid", out_valid, 1);

    // SUB with BranchZero taken; following instruction is squashed.
    drive(1, 9'h040, 4'd1, 32'd4, 32'd4, 6'd1);
    cycle();
    check("beq redirect_valid", redirect_valid, 1);
    check("beq redirect_pc", redirect_pc, 32'd4);
    drive(1, 9'h001, 4'd0, 32'd1, 32'd1, 6'd2);
    cycle();
    check("squash out_valid", out_valid, 0);
    check("redirect one cycle", redirect_valid, 0);

    // MUL: stall length and product.
    drive(1, 9'h001, 4'b1010, 32'h0001_0003, 32'h0002_0005, 6'd5);
    n = 0;
    for (int g = 0; g < 50; g++) begin
      cycle();
      if (s_stall) begin
        n++;
        if (out_valid !== 1'b0) check("mul out_valid during stall", out_valid, 0);
      end else break;
    end
    check("mul stall length", n, 33);
    check("mul result", alu_result_out, 32'h000B_000F);
    check("mul valid", out_valid, 1);
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    check("mul valid one cycle", out_valid, 0);

    // MUL aborted by flush at BUSY iteration 10.
    drive(1, 9'h001, 4'b1010, 32'd9, 32'd9, 6'd6);
    cycle();
    repeat (9) cycle();
    flush_in = 1;
    #1;
    check("flush drops stall", stall_out, 0);
    cycle();
    check("flush no result", out_valid, 0);
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    check("flush idle stall", stall_out, 0);
    drive(1, 9'h001, 4'd0, 32'd1, 32'd2, 6'd7);
    cycle();
    check("post-flush add", alu_result_out, 32'd3);
    check("post-flush valid", out_valid, 1);

    // Shift / compare / undefined op.
    drive(1, 9'h001, 4'd7, 32'h8000_0000, 32'd4, 6'd1);
    cycle();
    check("sra", alu_result_out, 32'hF800_0000);
    drive(1, 9'h001, 4'd11, 32'hFFFF_FFFF, 32'd0, 6'd1);
    cycle();
    check("slt", alu_result_out, 32'd1);
    drive(1, 9'h001, 4'd15, 32'h1234, 32'h5678, 6'd1);
    cycle();
    check("undefined op", alu_result_out, 32'd0);

    // Reset held two cycles in the middle of a multiply.
    drive(1, 9'h001, 4'b1010, 32'd7, 32'd3, 6'd2);
    repeat (5) cycle();
    rst = 1;
    repeat (2) cycle();
    check("midmul reset stall", stall_out, 0);
    check("midmul reset out_valid", out_valid, 0);
    check("midmul reset result", alu_result_out, 0);
    check("midmul reset pc", pc_out, 0);
    rst = 0;
    drive(1, 9'h001, 4'd0, 32'd5, 32'd7, 6'd4);
    cycle();
    check("after reset add", alu_result_out, 32'd12);
    check("after reset valid", out_valid, 1);

    // Randomized traffic; instruction held while the model says stalled.
    for (int i = 0; i < 3000; i++) begin
      if (!m_stall_last) begin
        in_valid  = ($urandom % 8) != 0;
        alu_op    = (($urandom % 10) == 0) ? 4'b1010 : 4'($urandom % 16);
        ctrl_in   = 9'($urandom);
        if (alu_op == 4'b1010 || ($urandom % 4) != 0) ctrl_in[7:5] = 3'b000;
        rs_in     = rval();
        rt_in     = rval();
        rd_in     = 6'($urandom);
        offset_in = rval();
        pc_in     = $urandom;
      end
      flush_in = ($urandom % 30) == 0;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
